image_beat_framer: RTL
======================

Name: image_beat_framer

Overview:
- Sits directly downstream of the imager subsystem's synchronised pixel output (80-bit beats, 8 pixels × 10 bit, `sys_clk` domain, no backpressure).
- Frames the raw beat stream into an AXI4-Stream video stream: tuser marks start-of-frame, tlast marks end-of-line.
- Buffers beats in a small FIFO so a stalling consumer (image processing / DMA packer) does not lose data until the FIFO fills.
- Reports frame completion and sticky error flags to the register block.

Parameters:
FIFO_DEPTH, 16, FIFO entries (power of 2, ≥4)
PIX_PER_BEAT, 8, pixels per input beat
PIX_W, 10, bits per pixel (beat width = PIX_PER_BEAT*PIX_W = 80)

Ports:
sys_clk  in  1  block clock
sys_rst_n  in  1  asynchronous active-low reset
new_frame  in  1  single-cycle pulse; arms/re-arms frame capture
imageRow  in  16  rows per frame, sampled on new_frame
imageCol  in  16  pixels per row, sampled on new_frame
clear_err  in  1  single-cycle pulse; clears err[3:0]
in_data  in  80  pixel beat
in_vld  in  1  in_data valid; no ready, beats cannot be stalled
m_axis_tdata  out  80  output beat
m_axis_tvalid  out  1  AXIS valid
m_axis_tready  in  1  AXIS ready
m_axis_tuser  out  1  first beat of frame
m_axis_tlast  out  1  last beat of a line
frame_done  out  1  one-cycle pulse, last beat of frame accepted
line_count  out  16  completed lines in current frame
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
err  out  4  sticky {geom, abort, stray, overflow}

Behaviour:
- Reset (async assert, sync release): every output is 0, state is IDLE, FIFO is empty, counters are 0.
- Geometry on new_frame:
  - Latch rows = imageRow.
  - Latch bpl = (imageCol+7)>>3, computed in 17 bits; imageCol=0xFFFF gives bpl=8192.
  - If imageRow==0 or imageCol==0: set err[3], go to IDLE, and do not arm.
- FSM states: IDLE, ARMED, ACTIVE.
  - IDLE: in_vld beats are discarded and set err[2] (stray). new_frame with valid geometry → ARMED.
  - ARMED: col_cnt=0, row_cnt=0, line_count=0. First in_vld beat is tagged sof=1 → ACTIVE.
  - ACTIVE: each in_vld beat increments col_cnt.
    - When col_cnt==bpl-1: tag eol=1, set col_cnt=0, increment row_cnt, increment line_count.
    - When the eol beat is also the last row (row_cnt==rows-1): pulse frame_done on the next cycle and go to IDLE.
  - new_frame while ARMED or ACTIVE: set err[1] (abort), re-latch geometry, go to ARMED (or IDLE if geometry is invalid).
    - The FIFO is NOT flushed; queued beats drain normally, and the truncated line carries no tlast.
  - new_frame coincident with in_vld: new_frame wins; that beat is discarded and sets err[2].
- FIFO:
  - Entry width is 82 bits: {sof, eol, data}.
  - Write on a tagged beat when not full.
  - When full and no read occurs in the same cycle: the beat is dropped, err[0] is set, and the counters still advance so geometry stays aligned.
  - When full and a read occurs in the same cycle: the write is accepted and occupancy is unchanged.
- Output:
  - Registered. A beat written at edge N is presented on m_axis_tvalid no earlier than after edge N+1.
  - tdata, tuser and tlast are held stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
  - Throughput is 1 beat/cycle with tready held high.
- fifo_level reflects writes and reads on the same edge.
- err:
  - Each bit is set by its event and cleared only by clear_err or reset.
  - If set and clear_err occur in the same cycle, set wins.

Test Plan:
- Frame with imageRow=2, imageCol=16 (bpl=2), 4 contiguous in_vld beats, tready=1 → 4 beats out; tuser on beat 0; tlast on beats 1 and 3; frame_done pulses once; line_count=2; err=0.
- imageCol=17 (bpl=3), imageRow=1, tready=0 → fifo_level reaches 3. Then tready=1 → 3 beats drain in order, tlast on beat 2 only.
- FIFO_DEPTH=16, tready=0, imageRow=1, imageCol=160 (20 beats) → fifo_level=16; err[0]=1; 4 beats dropped; frame_done still pulses after beat 20. Release tready → exactly 16 beats out.
- in_vld asserted in IDLE before any new_frame → no output beats; err=4'b0100. Then clear_err → err=0.
- new_frame after 3 beats of a bpl=4 frame → err[1]=1; the next beat is tagged tuser=1; the already-queued 3 beats drain with no tlast.
- new_frame with imageCol=0 → err[3]=1, state stays IDLE, and subsequent beats set err[2].

Source files
------------

// File: rtl/image_beat_framer_if.sv
// AXI4-Stream video output bundle for the image beat framer.
// master drives data/valid/user/last, slave returns ready.
interface image_beat_framer_if #(
    parameter int DATA_W = 80
);
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tuser;
    logic              m_axis_tlast;

    modport master (
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tuser,
        output m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tuser,
        input  m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/image_beat_framer.sv
// Frames imager beats into AXIS video (tuser=SOF, tlast=EOL) through a small FIFO.
// Latency: 2 cycles in->tvalid. Backpressure: FIFO absorbs stalls; beats drop with err[0] once full.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_rdy,
    output logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_wr;
    logic             do_rd;

    assign do_rd  = rd_rdy && (cnt != '0);
    assign do_wr  = wr_vld && ((cnt != (AW+1)'(DEPTH)) || do_rd);
    assign rd_vld = (cnt != '0);
    assign rd_dat = mem[rd_ptr];
    assign count  = cnt;

    always_ff @(posedge sys_clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module image_beat_framer #(
    parameter int FIFO_DEPTH   = 16,
    parameter int PIX_PER_BEAT = 8,
    parameter int PIX_W        = 10
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst_n,
    input  logic                            new_frame,
    input  logic [15:0]                     imageRow,
    input  logic [15:0]                     imageCol,
    input  logic                            clear_err,
    input  logic [PIX_PER_BEAT*PIX_W-1:0]   in_data,
    input  logic                            in_vld,
    image_beat_framer_if.master             axis,
    output logic                            frame_done,
    output logic [15:0]                     line_count,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [3:0]                      err
);
    localparam int DW = PIX_PER_BEAT * PIX_W;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

    state_t        state, state_nxt;
    logic [15:0]   rows;
    logic [16:0]   bpl;
    logic [16:0]   col_cnt;
    logic [15:0]   row_cnt;
    logic          geom_ok;
    logic          beat_take, tag_sof, tag_eol, frame_end;
    logic          wr_ok, handshake, out_load;
    logic [LW-1:0] fifo_cnt;
    logic          fifo_rd_vld;
    logic [DW+1:0] fifo_rd_dat;
    logic [DW-1:0] out_dat;
    logic          out_vld, out_sof, out_eol;
    logic [3:0]    err_set;

    assign geom_ok = (imageRow != 16'd0) && (imageCol != 16'd0);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (new_frame)
            state_nxt = geom_ok ? ARMED : IDLE;
        else if (beat_take) begin
            if (frame_end)            state_nxt = IDLE;
            else if (state == ARMED)  state_nxt = ACTIVE;
        end
    end

    always_comb begin
        beat_take = in_vld && !new_frame && (state != IDLE);
        tag_sof   = (state == ARMED);
        tag_eol   = (col_cnt == bpl - 17'd1);
        frame_end = tag_eol && (row_cnt == rows - 16'd1);
    end

    // Counters advance on every taken beat, even a dropped one, to keep line alignment.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rows       <= '0;
            bpl        <= '0;
            col_cnt    <= '0;
            row_cnt    <= '0;
            line_count <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= beat_take && frame_end;
            if (new_frame) begin
                rows       <= imageRow;
                bpl        <= ({1'b0, imageCol} + 17'd7) >> 3;
                col_cnt    <= '0;
                row_cnt    <= '0;
                line_count <= '0;
            end else if (beat_take) begin
                if (tag_eol) begin
                    col_cnt    <= '0;
                    row_cnt    <= row_cnt + 16'd1;
                    line_count <= line_count + 16'd1;
                end else begin
                    col_cnt    <= col_cnt + 17'd1;
                end
            end
        end
    end

    // Output register counts toward occupancy, so total capacity is FIFO_DEPTH.
    assign fifo_level = fifo_cnt + LW'(out_vld);
    assign handshake  = out_vld && axis.m_axis_tready;
    assign wr_ok      = (fifo_level != LW'(FIFO_DEPTH)) || handshake;
    assign out_load   = fifo_rd_vld && (!out_vld || axis.m_axis_tready);

    fifo #(.WIDTH(DW + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wr_vld    (beat_take && wr_ok),
        .wr_dat    ({tag_sof, tag_eol, in_data}),
        .rd_rdy    (!out_vld || axis.m_axis_tready),
        .rd_vld    (fifo_rd_vld),
        .rd_dat    (fifo_rd_dat),
        .count     (fifo_cnt)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_vld <= 1'b0;
            out_sof <= 1'b0;
            out_eol <= 1'b0;
            out_dat <= '0;
        end else if (out_load) begin
            out_vld <= 1'b1;
            {out_sof, out_eol, out_dat} <= fifo_rd_dat;
        end else if (axis.m_axis_tready) begin
            out_vld <= 1'b0;
        end
    end

    assign axis.m_axis_tdata  = out_dat;
    assign axis.m_axis_tvalid = out_vld;
    assign axis.m_axis_tuser  = out_sof;
    assign axis.m_axis_tlast  = out_eol;

    assign err_set[3] = new_frame && !geom_ok;
    assign err_set[2] = in_vld && (new_frame || state == IDLE);
    assign err_set[1] = new_frame && (state != IDLE);
    assign err_set[0] = beat_take && !wr_ok;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) err <= '0;
        else            err <= (clear_err ? 4'd0 : err) | err_set;
    end
endmodule
